// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: memory-referencing icodes and the memory-requester state type.
package y86_pkg;

  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_req_state_e;

endpackage

// File: rtl/mem_op_decode.sv
// Combinational memory-stage decode: icode and operands -> access kind, entry address, write data.
module mem_op_decode
  import y86_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic        is_read,
  output logic        is_write,
  output logic [63:0] addr,
  output logic [63:0] wdata
);

  always_comb begin
    is_read  = 1'b0;
    is_write = 1'b0;
    addr     = '0;
    wdata    = '0;
    case (icode)
      ICODE_RMMOVQ, ICODE_PUSHQ: begin
        is_write = 1'b1;
        addr     = valE;
        wdata    = valA;
      end
      ICODE_CALL: begin
        is_write = 1'b1;
        addr     = valE;
        wdata    = valP;
      end
      ICODE_MRMOVQ: begin
        is_read = 1'b1;
        addr    = valE;
      end
      // ret and popq read through the stack pointer, which arrives as valA
      ICODE_RET, ICODE_POPQ: begin
        is_read = 1'b1;
        addr    = valA;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/y86_mem_requester.sv
// Memory-stage requester: one handshaked data-memory access per start, with range checking.
// Optional stalled-responder timeout is compiled in with MEM_REQ_TIMEOUT_EN.
//
//  state   | meaning
//  IDLE    | waiting for start; request registers loaded on accept
//  REQ     | mem_req held high until mem_ack (or timeout)
//  DONE    | one-cycle completion, done=1
module y86_mem_requester
  import y86_pkg::*;
#(
  parameter int MEM_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic [63:0] valM,
  output logic        busy,
  output logic        done,
  output logic        dmem_error
);

  mem_req_state_e state, state_n;

  logic        dec_read, dec_write;
  logic [63:0] dec_addr, dec_wdata;

  logic        req_n, we_n, err_n;
  logic [63:0] addr_n, wdata_n, valm_n;

  mem_op_decode u_decode (
    .icode    (icode),
    .valA     (valA),
    .valE     (valE),
    .valP     (valP),
    .is_read  (dec_read),
    .is_write (dec_write),
    .addr     (dec_addr),
    .wdata    (dec_wdata)
  );

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_n = state;
    req_n   = mem_req;
    we_n    = mem_we;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    valm_n  = valM;
    err_n   = dmem_error;
`ifdef MEM_REQ_TIMEOUT_EN
    wait_cnt_n = wait_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          we_n    = dec_write;
          addr_n  = dec_addr;
          wdata_n = dec_wdata;
          err_n   = 1'b0;
          if (!dec_read && !dec_write) begin
            state_n = ST_DONE;
          end else if (dec_addr >= 64'(MEM_WORDS)) begin
            err_n   = 1'b1;
            state_n = ST_DONE;
          end else begin
            req_n   = 1'b1;
            state_n = ST_REQ;
`ifdef MEM_REQ_TIMEOUT_EN
            wait_cnt_n = '0;
`endif
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          req_n   = 1'b0;
          state_n = ST_DONE;
          if (!mem_we) valm_n = mem_rdata;
        end else begin
`ifdef MEM_REQ_TIMEOUT_EN
          wait_cnt_n = wait_cnt + 1'b1;
          if (wait_cnt_n == CNT_W'(TIMEOUT_CYCLES)) begin
            req_n   = 1'b0;
            err_n   = 1'b1;
            state_n = ST_DONE;
          end
`endif
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      valM       <= '0;
      dmem_error <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      mem_req    <= req_n;
      mem_we     <= we_n;
      mem_addr   <= addr_n;
      mem_wdata  <= wdata_n;
      valM       <= valm_n;
      dmem_error <= err_n;
      busy       <= (state_n != ST_IDLE);
      done       <= (state_n == ST_DONE);
    end
  end

`ifdef MEM_REQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= '0;
    else        wait_cnt <= wait_cnt_n;
  end
`endif

endmodule

// File: tb/tb_y86_mem_requester.sv
// Self-checking bench for y86_mem_requester: directed plan cases plus randomized ops vs a table model.
module tb_y86_mem_requester;

  localparam int MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valA, valE, valP;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic [63:0] valM;
  logic        busy, done, dmem_error;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_valm;

  y86_mem_requester #(.MEM_WORDS(MEM_WORDS), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .icode      (icode),
    .valA       (valA),
    .valE       (valE),
    .valP       (valP),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .valM       (valM),
    .busy       (busy),
    .done       (done),
    .dmem_error (dmem_error)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          access;
    bit          we;
    bit          bad;
    logic [63:0] addr;
    logic [63:0] wdata;
  } exp_t;

  // Reference: the icode table, then the range rule on the full 64-bit address
  function automatic exp_t model(input logic [3:0] ic, input logic [63:0] a, e, p);
    exp_t x;
    x = '{access: 1'b0, we: 1'b0, bad: 1'b0, addr: 64'd0, wdata: 64'd0};
    if (ic == 4'h4 || ic == 4'hA) x = '{1'b1, 1'b1, 1'b0, e, a};
    else if (ic == 4'h8)          x = '{1'b1, 1'b1, 1'b0, e, p};
    else if (ic == 4'h5)          x = '{1'b1, 1'b0, 1'b0, e, 64'd0};
    else if (ic == 4'h9 || ic == 4'hB) x = '{1'b1, 1'b0, 1'b0, a, 64'd0};
    x.bad = x.access && (x.addr >= 64'(MEM_WORDS));
    return x;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic run_op(input logic [3:0] ic, input logic [63:0] a, e, p,
                        input int wait_n, input logic [63:0] rd, input bit hold_start);
    exp_t x;
    bit   ok;
    int   busy_n;
    x  = model(ic, a, e, p);
    ok = x.access && !x.bad;
    @(negedge clk);
    icode = ic; valA = a; valE = e; valP = p; start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    icode = 4'($urandom); valA = rand64(); valE = rand64(); valP = rand64();
    if (!ok) begin
      mem_ack = 1'b1;
      mem_rdata = rand64();
    end
    busy_n = 0;
    @(negedge clk);
    busy_n += int'(busy);
    if (ok) begin
      check_val("req_rise", mem_req, 1);
      check_val("we", mem_we, x.we);
      check_val("addr", mem_addr, x.addr);
      if (x.we) check_val("wdata", mem_wdata, x.wdata);
      check_val("done_early", done, 0);
      for (int i = 0; i < wait_n; i++) begin
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        busy_n += int'(busy);
        check_val("req_hold", mem_req, 1);
        check_val("addr_hold", mem_addr, x.addr);
      end
      mem_ack = 1'b1;
      mem_rdata = rd;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_rdata = rand64();
      start = 1'b0;
      @(negedge clk);
      busy_n += int'(busy);
      if (!x.we) exp_valm = rd;
    end
    check_val("done", done, 1);
    check_val("req_low", mem_req, 0);
    check_val("valM", valM, exp_valm);
    check_val("err", dmem_error, x.bad);
    @(posedge clk); #1;
    start = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    busy_n += int'(busy);
    check_val("done_pulse", done, 0);
    check_val("busy_cycles", 64'(busy_n), ok ? 64'(wait_n + 2) : 64'd1);
    check_val("err_hold", dmem_error, x.bad);
    check_val("valM_hold", valM, exp_valm);
  endtask

  task automatic stall_test();
    int req_n, done_n;
    @(negedge clk);
    icode = 4'h8; valE = 64'd5; valP = 64'h77; valA = 64'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    req_n = 0; done_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_n  += int'(mem_req);
      done_n += int'(done);
    end
`ifdef MEM_REQ_TIMEOUT_EN
    check_val("to_req_cycles", 64'(req_n), 64'd16);
    check_val("to_done", 64'(done_n), 64'd1);
    check_val("to_err", dmem_error, 1);
    check_val("to_valM", valM, exp_valm);
`else
    check_val("stall_req_cycles", 64'(req_n), 64'd20);
    check_val("stall_no_done", 64'(done_n), 64'd0);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check_val("stall_done", done, 1);
    check_val("stall_err", dmem_error, 0);
    @(negedge clk);
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; icode = 4'h0;
    valA = '0; valE = '0; valP = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    exp_valm = '0;
    repeat (2) @(negedge clk);
    check_val("rst_req", mem_req, 0);
    check_val("rst_we", mem_we, 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_wdata", mem_wdata, 0);
    check_val("rst_valM", valM, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", dmem_error, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'h4, 64'hDEADBEEF, 64'h10, 64'h0, 0, 64'h0, 1'b0);
    run_op(4'hB, 64'h20, 64'h0, 64'h0, 3, 64'h1234, 1'b0);
    run_op(4'h5, 64'h0, 64'd1024, 64'h0, 0, 64'h0, 1'b0);
    run_op(4'h1, 64'h0, 64'h0, 64'h0, 0, 64'h0, 1'b0);
    run_op(4'h6, 64'h0, 64'h0, 64'h0, 0, 64'h0, 1'b1);
    run_op(4'h9, 64'd1023, 64'h0, 64'h0, 1, 64'hCAFE, 1'b1);
    run_op(4'h8, 64'h0, 64'hFFFF_FFFF_0000_0010, 64'h40, 0, 64'h0, 1'b0);
    stall_test();

    // asynchronous reset while a request is outstanding
    @(negedge clk);
    icode = 4'hA; valA = 64'h55; valE = 64'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_val("pre_rst_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_req", mem_req, 0);
    check_val("async_rst_busy", busy, 0);
    exp_valm = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_valM", valM, exp_valm);
    run_op(4'hA, 64'h99, 64'd8, 64'h0, 2, 64'h0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [3:0]  ic;
      logic [63:0] a, e;
      ic = ($urandom_range(0, 2) == 0) ? 4'($urandom) :
           ($urandom_range(0, 1) == 0) ? 4'h5 : 4'hB;
      a = ($urandom_range(0, 4) == 0) ? rand64() : 64'($urandom_range(1020, 1027));
      e = ($urandom_range(0, 4) == 0) ? rand64() : 64'($urandom_range(0, MEM_WORDS - 1));
      if ($urandom_range(0, 1) == 0) ic = (ic == 4'h5) ? 4'h4 : (ic == 4'hB ? 4'hA : ic);
      run_op(ic, a, e, rand64(), $urandom_range(0, 4), rand64(), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
